// File: rtl/microseq.sv
// microseq: microcode sequencer that turns opcode, flags and T-state into a 16-bit control word
//   clk        in   state advances on the falling edge
//   rst        in   synchronous active-high reset
//   opcode     in   instruction register upper nibble, decoded combinationally
//   flag_c/z   in   registered carry / zero flags, decoded combinationally
//   ctrl_word  out  {HLT,PC_INC,PC_EN,PC_LOAD,MEM_LOAD,MEM_EN,MEM_WR,IR_LOAD,
//                    IR_EN,A_LOAD,A_EN,B_LOAD,ADDER_SUB,ADDER_EN,OUT_LOAD,FLAGS_LOAD}
//   step       out  current T-state 0..5
//   halted     out  halt latch, cleared only by rst
//   instr_done out  high during the last step of the instruction
module microseq #(
  parameter int EARLY_END = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl_word,
  output logic [2:0]  step,
  output logic        halted,
  output logic        instr_done
);
  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [15:0] c3, c4, c5, cw;
  logic [2:0]  last, done_step;
  logic        hlt_now;
  // execute-phase words; steps past an instruction's last step stay 0
  always_comb begin
    c3 = 16'h0000;
    c4 = 16'h0000;
    c5 = 16'h0000;
    last = 3'd3;
    case (opcode)
      4'h1: begin c3 = 16'h0880; c4 = 16'h0440; last = 3'd4; end
      4'h2, 4'h3: begin
        c3 = 16'h0880;
        c4 = 16'h0410;
        c5 = opcode[0] ? 16'h004D : 16'h0045;
        last = 3'd5;
      end
      4'h4: begin c3 = 16'h0880; c4 = 16'h0220; last = 3'd4; end
      4'h5: c3 = 16'h00C0;
      4'h6: c3 = 16'h1080;
      4'h7: c3 = flag_c ? 16'h1080 : 16'h0000;
      4'h8: c3 = flag_z ? 16'h1080 : 16'h0000;
      4'hE: c3 = 16'h0022;
      4'hF: c3 = 16'h8000;
      default: ;
    endcase
  end
  always_comb begin
    cw = 16'h0000;
    case (step_q)
      3'd0: cw = 16'h2800;
      3'd1: cw = 16'h4000;
      3'd2: cw = 16'h0500;
      3'd3: cw = c3;
      3'd4: cw = c4;
      3'd5: cw = c5;
      default: cw = 16'h0000;
    endcase
  end
  assign done_step = (EARLY_END != 0) ? last : 3'd5;
  assign hlt_now   = !halted_q && opcode == 4'hF && step_q == 3'd3;
  // halting freezes step at 3; 5 and the unreachable 6/7 all fall back to 0
  always_comb begin
    halted_d = halted_q | hlt_now;
    step_d = (halted_q || hlt_now) ? step_q
           : (step_q >= 3'd5 || (EARLY_END != 0 && step_q == last)) ? 3'd0
           : step_q + 3'd1;
  end
  always_ff @(negedge clk) begin
    if (rst) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end
  assign ctrl_word  = halted_q ? 16'h8000 : cw;
  assign step       = step_q;
  assign halted     = halted_q;
  assign instr_done = !halted_q && step_q == done_step;
endmodule

// File: tb/tb_microseq.sv
// tb_microseq: directed self-checking bench for microseq in both EARLY_END modes
module tb_microseq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic        flag_c = 1'b0, flag_z = 1'b0;
  logic [15:0] cw1, cw0;
  logic [2:0]  st1, st0;
  logic        hl1, hl0, dn1, dn0;
  int errs = 0;
  int checks = 0;
  microseq #(.EARLY_END(1)) u_e1 (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .ctrl_word(cw1), .step(st1), .halted(hl1), .instr_done(dn1)
  );
  microseq #(.EARLY_END(0)) u_e0 (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .ctrl_word(cw0), .step(st0), .halted(hl0), .instr_done(dn0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask
  task automatic look(input string t, input bit e, input logic [15:0] cw, input logic [2:0] st,
                      input logic dn, input logic hl);
    #1;
    chk({t, ".cw"}, e ? cw1 : cw0, cw);
    chk({t, ".step"}, e ? st1 : st0, st);
    chk({t, ".done"}, e ? dn1 : dn0, dn);
    chk({t, ".halt"}, e ? hl1 : hl0, hl);
  endtask
  task automatic tk(input string t, input bit e, input logic [15:0] cw, input logic [2:0] st,
                    input logic dn, input logic hl);
    look(t, e, cw, st, dn, hl);
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic run(input string t, input bit e, input logic [3:0] op,
                     input logic [15:0] c3, input logic [15:0] c4, input logic [15:0] c5,
                     input int last);
    logic [15:0] exp_cw [6];
    exp_cw[0] = 16'h2800; exp_cw[1] = 16'h4000; exp_cw[2] = 16'h0500;
    exp_cw[3] = c3; exp_cw[4] = c4; exp_cw[5] = c5;
    opcode = op;
    for (int k = 0; k <= (e ? last : 5); k++)
      tk($sformatf("%s.T%0d", t, k), e, exp_cw[k], 3'(k), e ? (k == last) : (k == 5), 1'b0);
  endtask
  initial begin
    @(negedge clk);
    #1;
    rst = 1'b0;
    look("reset", 1, 16'h2800, 3'd0, 1'b0, 1'b0);
    run("ldi", 1, 4'h5, 16'h00C0, 16'h0000, 16'h0000, 3);
    run("add", 1, 4'h2, 16'h0880, 16'h0410, 16'h0045, 5);
    run("sub", 1, 4'h3, 16'h0880, 16'h0410, 16'h004D, 5);
    flag_c = 1'b0;
    run("jc0", 1, 4'h7, 16'h0000, 16'h0000, 16'h0000, 3);
    flag_c = 1'b1;
    run("jc1", 1, 4'h7, 16'h1080, 16'h0000, 16'h0000, 3);
    flag_z = 1'b1;
    run("jz1", 1, 4'h8, 16'h1080, 16'h0000, 16'h0000, 3);
    flag_z = 1'b0;
    run("jz0", 1, 4'h8, 16'h0000, 16'h0000, 16'h0000, 3);
    run("lda", 1, 4'h1, 16'h0880, 16'h0440, 16'h0000, 4);
    run("sta", 1, 4'h4, 16'h0880, 16'h0220, 16'h0000, 4);
    run("jmp", 1, 4'h6, 16'h1080, 16'h0000, 16'h0000, 3);
    run("out", 1, 4'hE, 16'h0022, 16'h0000, 16'h0000, 3);
    run("nop", 1, 4'h0, 16'h0000, 16'h0000, 16'h0000, 3);
    run("undef", 1, 4'hB, 16'h0000, 16'h0000, 16'h0000, 3);
    run("hlt", 1, 4'hF, 16'h8000, 16'h0000, 16'h0000, 3);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) opcode = 4'h5;
      tk($sformatf("halt%0d", i), 1, 16'h8000, 3'd3, 1'b0, 1'b1);
    end
    do_reset();
    look("halt_rst", 1, 16'h2800, 3'd0, 1'b0, 1'b0);
    opcode = 4'h1;
    tk("ldarst.T0", 1, 16'h2800, 3'd0, 1'b0, 1'b0);
    tk("ldarst.T1", 1, 16'h4000, 3'd1, 1'b0, 1'b0);
    tk("ldarst.T2", 1, 16'h0500, 3'd2, 1'b0, 1'b0);
    tk("ldarst.T3", 1, 16'h0880, 3'd3, 1'b0, 1'b0);
    look("ldarst.T4", 1, 16'h0440, 3'd4, 1'b1, 1'b0);
    do_reset();
    look("ldarst.after", 1, 16'h2800, 3'd0, 1'b0, 1'b0);
    opcode = 4'h5;
    @(negedge clk);
    #1;
    look("ldarst.next", 1, 16'h4000, 3'd1, 1'b0, 1'b0);
    do_reset();
    opcode = 4'hF;
    tk("hltrst.T0", 1, 16'h2800, 3'd0, 1'b0, 1'b0);
    tk("hltrst.T1", 1, 16'h4000, 3'd1, 1'b0, 1'b0);
    tk("hltrst.T2", 1, 16'h0500, 3'd2, 1'b0, 1'b0);
    look("hltrst.T3", 1, 16'h8000, 3'd3, 1'b1, 1'b0);
    do_reset();
    look("hltrst.after", 1, 16'h2800, 3'd0, 1'b0, 1'b0);
    do_reset();
    look("fx.reset", 0, 16'h2800, 3'd0, 1'b0, 1'b0);
    run("fx.ldi", 0, 4'h5, 16'h00C0, 16'h0000, 16'h0000, 3);
    run("fx.lda", 0, 4'h1, 16'h0880, 16'h0440, 16'h0000, 4);
    run("fx.add", 0, 4'h2, 16'h0880, 16'h0410, 16'h0045, 5);
    opcode = 4'hF;
    tk("fx.hlt.T0", 0, 16'h2800, 3'd0, 1'b0, 1'b0);
    tk("fx.hlt.T1", 0, 16'h4000, 3'd1, 1'b0, 1'b0);
    tk("fx.hlt.T2", 0, 16'h0500, 3'd2, 1'b0, 1'b0);
    tk("fx.hlt.T3", 0, 16'h8000, 3'd3, 1'b0, 1'b0);
    tk("fx.halt", 0, 16'h8000, 3'd3, 1'b0, 1'b1);
    do_reset();
    look("fx.after", 0, 16'h2800, 3'd0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/microseq.md
MICROSEQ -- requirements
Module: microseq

Interface
REQ-001 SHALL provide parameter EARLY_END, default 1, meaning 1 = variable-length instructions (step returns to 0 after the instruction's last active step) and 0 = fixed 6-step cycle.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state SHALL update on its falling edge.
REQ-003 SHALL provide port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL provide port opcode, input, 4, instruction register upper nibble.
REQ-005 SHALL provide ports flag_c and flag_z, input, 1 each, registered carry and zero flags from the datapath.
REQ-006 SHALL provide port ctrl_word, output, 16, the control word; combinational from step, opcode, flags and halted.
REQ-007 SHALL provide port step, output, 3, current T-state (0..5).
REQ-008 SHALL provide port halted, output, 1, halt latch.
REQ-009 SHALL provide port instr_done, output, 1, high during the last step of the current instruction.

Function
REQ-010 ctrl_word bits SHALL be: 15 HLT, 14 PC_INC, 13 PC_EN, 12 PC_LOAD, 11 MEM_LOAD, 10 MEM_EN, 9 MEM_WR, 8 IR_LOAD, 7 IR_EN, 6 A_LOAD, 5 A_EN, 4 B_LOAD, 3 ADDER_SUB, 2 ADDER_EN, 1 OUT_LOAD, 0 FLAGS_LOAD.
REQ-011 Opcodes SHALL be: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; 9-D SHALL behave as NOP.
REQ-012 Fetch SHALL be opcode-independent: T0 = 0x2800 (PC_EN|MEM_LOAD), T1 = 0x4000 (PC_INC), T2 = 0x0500 (MEM_EN|IR_LOAD).
REQ-013 LDA: T3 IR_EN|MEM_LOAD (0x0880), T4 MEM_EN|A_LOAD (0x0440); last step T4.
REQ-014 ADD: T3 0x0880, T4 MEM_EN|B_LOAD (0x0410), T5 ADDER_EN|A_LOAD|FLAGS_LOAD (0x0045); last step T5.
REQ-015 SUB: same as ADD with ADDER_SUB also set at T5 (0x004D); last step T5.
REQ-016 STA: T3 0x0880, T4 A_EN|MEM_WR (0x0220); last step T4.
REQ-017 LDI: T3 IR_EN|A_LOAD (0x00C0); JMP: T3 IR_EN|PC_LOAD (0x1080); OUT: T3 A_EN|OUT_LOAD (0x0022); last step T3 for each.
REQ-018 JC / JZ: T3 SHALL be 0x1080 when flag_c / flag_z is 1, else 0x0000; last step T3 regardless of the flag.
REQ-019 NOP and undefined opcodes: T3 SHALL be 0x0000; last step T3.
REQ-020 HLT: T3 SHALL be 0x8000; the falling edge ending T3 SHALL set halted=1 and hold step at 3.
REQ-021 While halted=1, ctrl_word SHALL be 0x8000, step SHALL hold 3, and instr_done SHALL be 0; only rst clears halted.
REQ-022 With EARLY_END=1, step SHALL go to 0 on the edge ending the last step, else increment.
REQ-023 With EARLY_END=0, step SHALL count 0..5 and wrap to 0, and steps beyond an instruction's last step SHALL output 0x0000.
REQ-024 instr_done SHALL be high during the last step when EARLY_END=1, and during T5 when EARLY_END=0 (HLT excepted, per REQ-021).
REQ-025 Opcode and flags SHALL be sampled combinationally; no internal copy SHALL be kept.
REQ-026 Step values 6-7 SHALL be unreachable; if reached, ctrl_word SHALL be 0x0000 and the next edge SHALL return step to 0.

Reset
REQ-027 rst=1 at a falling edge SHALL force step=0 and halted=0 regardless of state; this includes mid-instruction and while halted.
REQ-028 After reset, outputs SHALL be ctrl_word=0x2800, step=0, halted=0, instr_done=0.
REQ-029 rst SHALL take priority over halt set and over step advance at the same edge.

Verification
REQ-030 Reset then LDI (opcode 5), EARLY_END=1 -> ctrl_word 0x2800, 0x4000, 0x0500, 0x00C0 with instr_done=1 at T3, then step=0.
REQ-031 ADD then SUB -> T5 = 0x0045, then T5 = 0x004D; instr_done=1 only at T5; step sequence 0-5,0-5.
REQ-032 JC with flag_c=0 then flag_c=1, JZ with flag_z=1 -> T3 = 0x0000, then 0x1080, then 0x1080.
REQ-033 HLT -> T3 0x8000, then halted=1, step=3 held for 10 cycles; rst pulse -> step=0, halted=0, ctrl_word=0x2800.
REQ-034 EARLY_END=0, LDI -> T3 0x00C0, T4 and T5 0x0000, instr_done only at T5.
REQ-035 rst asserted at T4 of LDA -> next edge step=0, ctrl_word=0x2800, with no A_LOAD cycle issued afterwards.
